// File: rtl/mmio_bus_bridge.sv
// Load/store bridge from the core memory stage to N memory-mapped targets with base/mask
// decode, valid/ready request handshake, target wait states and registered error responses.
module mmio_bus_bridge #(
    parameter int unsigned                N_TGT    = 2,
    parameter int unsigned                ADDR_W   = 32,
    parameter logic [N_TGT*ADDR_W-1:0]    TGT_BASE = {32'h0003_2000, 32'h0000_0000},
    parameter logic [N_TGT*ADDR_W-1:0]    TGT_MASK = {32'hFFFF_F000, 32'hFFFF_C000},
    parameter int unsigned                TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_err,
    output logic [N_TGT-1:0]      tgt_sel,
    output logic                  tgt_we,
    output logic [3:0]            tgt_be,
    output logic [ADDR_W-1:0]     tgt_addr,
    output logic [31:0]           tgt_wdata,
    input  logic [N_TGT*32-1:0]   tgt_rdata,
    input  logic [N_TGT-1:0]      tgt_ready
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t             state_q, state_d;
    logic               rst_meta, rst_sync_n;
    logic [CNT_W-1:0]   cnt_q;
    logic               lat_we, lat_unsigned;
    logic [1:0]         lat_size, lat_off;
    logic               misaligned, hit_any, sel_ready, timed_out;
    logic [N_TGT-1:0]   hit_oh;
    logic [3:0]         be;
    logic [31:0]        wdata, sel_rdata, byte_sh, half_sh, load_data;

    // Reset asserts asynchronously but is released in step with clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // Request decode: alignment, lowest-index window match, lane steering.
    always_comb begin
        unique case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
        hit_oh  = '0;
        hit_any = 1'b0;
        for (int i = 0; i < N_TGT; i++) begin
            if (!hit_any && ((req_addr & TGT_MASK[i*ADDR_W +: ADDR_W]) ==
                             TGT_BASE[i*ADDR_W +: ADDR_W])) begin
                hit_oh[i] = 1'b1;
                hit_any   = 1'b1;
            end
        end
        unique case (req_size)
            2'd0: begin
                be    = 4'b0001 << req_addr[1:0];
                wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = req_wdata;
            end
        endcase
    end

    // Selected target's completion and load alignment.
    always_comb begin
        sel_ready = |(tgt_ready & tgt_sel);
        sel_rdata = '0;
        for (int i = 0; i < N_TGT; i++) begin
            if (tgt_sel[i]) sel_rdata = sel_rdata | tgt_rdata[i*32 +: 32];
        end
        timed_out = (cnt_q == CNT_W'(TIMEOUT));
        byte_sh   = sel_rdata >> {lat_off, 3'b000};
        half_sh   = sel_rdata >> {lat_off[1], 4'b0000};
        unique case (lat_size)
            2'd0:    load_data = lat_unsigned ? {24'h0, byte_sh[7:0]}
                                              : {{24{byte_sh[7]}}, byte_sh[7:0]};
            2'd1:    load_data = lat_unsigned ? {16'h0, half_sh[15:0]}
                                              : {{16{half_sh[15]}}, half_sh[15:0]};
            default: load_data = sel_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state_q <= StIdle;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) state_d = (misaligned || !hit_any) ? StResp : StAccess;
            end
            StAccess: begin
                if (sel_ready || timed_out) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cnt_q        <= '0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= 2'd0;
            lat_off      <= 2'd0;
            rsp_rdata    <= '0;
            rsp_err      <= 2'd0;
            tgt_sel      <= '0;
            tgt_we       <= 1'b0;
            tgt_be       <= 4'b0;
            tgt_addr     <= '0;
            tgt_wdata    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        cnt_q        <= '0;
                        lat_we       <= req_we;
                        lat_unsigned <= req_unsigned;
                        lat_size     <= req_size;
                        lat_off      <= req_addr[1:0];
                        rsp_rdata    <= '0;
                        if (misaligned) begin
                            rsp_err <= 2'd1;
                        end else if (!hit_any) begin
                            rsp_err <= 2'd2;
                        end else begin
                            tgt_sel   <= hit_oh;
                            tgt_we    <= req_we;
                            tgt_be    <= be;
                            tgt_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            tgt_wdata <= wdata;
                        end
                    end
                end
                StAccess: begin
                    if (sel_ready || timed_out) begin
                        rsp_err   <= sel_ready ? 2'd0 : 2'd3;
                        rsp_rdata <= (sel_ready && !lat_we) ? load_data : 32'h0;
                        tgt_sel   <= '0;
                        tgt_we    <= 1'b0;
                        tgt_be    <= 4'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StResp: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed bench for mmio_bus_bridge: a responder model for two targets and a scoreboard of
// expected responses (data, error code, latency from accept) checked as responses appear.
module tb_mmio_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [1:0]  tgt_sel;
    logic        tgt_we;
    logic [3:0]  tgt_be;
    logic [31:0] tgt_addr;
    logic [31:0] tgt_wdata;
    logic [63:0] tgt_rdata;
    logic [1:0]  tgt_ready;

    logic [31:0] rd0 = '0, rd1 = '0;
    logic [1:0]  stray = 2'b00;
    int          ready_delay = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    mmio_bus_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .tgt_sel      (tgt_sel),
        .tgt_we       (tgt_we),
        .tgt_be       (tgt_be),
        .tgt_addr     (tgt_addr),
        .tgt_wdata    (tgt_wdata),
        .tgt_rdata    (tgt_rdata),
        .tgt_ready    (tgt_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: the selected target answers after ready_delay ACCESS cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        wcnt <= 0;
        else if (|tgt_sel) wcnt <= wcnt + 1;
        else               wcnt <= 0;
    end
    assign tgt_ready = ((wcnt >= ready_delay) ? tgt_sel : 2'b00) | (stray & ~tgt_sel);
    assign tgt_rdata = {rd1, rd0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {30'h0, rsp_err}, {30'h0, e.err});
                chk("rsp_latency", cyc + 1 - e.acc, e.lat);
            end
        end
    end

    // Presents a request (left asserted) and returns just after its accept edge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input bit push,
                          input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                          input int exp_lat);
        int n = 0;
        exp_t e;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", {31'h0, req_ready}, 32'h1);
            return;
        end
        @(posedge clk);
        #1;
        if (push) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.lat   = exp_lat;
            e.acc   = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic chk_access(input string tag, input logic [1:0] sel, input logic we,
                              input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wd);
        chk({tag, "_sel"}, {30'h0, tgt_sel}, {30'h0, sel});
        chk({tag, "_we"}, {31'h0, tgt_we}, {31'h0, we});
        chk({tag, "_be"}, {28'h0, tgt_be}, {28'h0, be});
        chk({tag, "_addr"}, tgt_addr, addr);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h0);
        if (we) chk({tag, "_wdata"}, tgt_wdata, wd);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, {30'h0, rsp_err}, 32'h0);
        chk({tag, "_tgt_sel"}, {30'h0, tgt_sel}, 32'h0);
        chk({tag, "_tgt_be"}, {27'h0, tgt_we, tgt_be}, 32'h0);
        chk({tag, "_tgt_addr"}, tgt_addr, 32'h0);
        chk({tag, "_tgt_wdata"}, tgt_wdata, 32'h0);
    endtask

    initial begin
        #12;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // lb signed, first-cycle ready
        rd0 = 32'h1180_7F22;
        ready_delay = 0;
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 32'hFFFF_FF80, 2'd0, 2);
        chk_access("lb", 2'b01, 1'b0, 4'b0100, 32'h0, 32'h0);
        drain();

        // sh
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0106, 32'h1234_BEEF, 1'b1, 32'h0, 2'd0, 2);
        chk_access("sh", 2'b01, 1'b1, 4'b1100, 32'h0000_0104, 32'hBEEF_BEEF);
        drain();

        // Misaligned and unmapped never select a target
        do_req(1'b0, 2'd1, 1'b1, 32'h0003_2003, 32'h0, 1'b1, 32'h0, 2'd1, 1);
        chk("misal_sel", {30'h0, tgt_sel}, 32'h0);
        drain();
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0, 2'd1, 1);
        drain();
        do_req(1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, 1'b1, 32'h0, 2'd2, 1);
        chk("unmap_sel", {30'h0, tgt_sel}, 32'h0);
        drain();

        // GPIO withholds ready 3 cycles; a stray ready from target0 must be ignored
        rd1 = 32'h0000_000A;
        ready_delay = 3;
        stray = 2'b01;
        do_req(1'b0, 2'd2, 1'b0, 32'h0003_2004, 32'h0, 1'b1, 32'h0000_000A, 2'd0, 5);
        chk_access("gpio", 2'b10, 1'b0, 4'b1111, 32'h0003_2004, 32'h0);
        drain();
        stray = 2'b00;

        // Target never ready
        ready_delay = 1000;
        do_req(1'b0, 2'd2, 1'b0, 32'h0003_2008, 32'h0, 1'b1, 32'h0, 2'd3, 17);
        drain();
        chk("timeout_sel_drop", {30'h0, tgt_sel}, 32'h0);

        // Back-to-back held requests
        rd0 = 32'h8001_1234;
        ready_delay = 0;
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 32'hFFFF_8001, 2'd0, 2);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0, 1'b1, 32'h0000_0080, 2'd0, 2);
        chk("b2b_ready_low", {31'h0, req_ready}, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_0055, 1'b1, 32'h0, 2'd0, 2);
        chk_access("sb", 2'b01, 1'b1, 4'b0010, 32'h0, 32'h5555_5555);
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0000, 32'h0, 1'b1, 32'h0000_1234, 2'd0, 2);
        drain();

        // Reset mid-access aborts with no response
        ready_delay = 1000;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 2'd0, 0);
        chk("pre_rst_sel", {30'h0, tgt_sel}, 32'h1);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rd0 = 32'h1234_5678;
        ready_delay = 0;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h1234_5678, 2'd0, 2);
        drain();

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mmio_bus_bridge.md
Name: mmio_bus_bridge

Overview:
- Parametrised load/store bridge between the core's memory stage and N memory-mapped targets (BRAM data port, GPIO, UART, timers).
- Replaces fixed-range decode with per-target base/mask windows.
- Adds a valid/ready request handshake and multi-cycle target wait states.
- Adds misalignment, unmapped-address and timeout error reporting on a registered response channel.

Parameters:
N_TGT, 2, number of targets (1..8)
ADDR_W, 32, address width
TGT_BASE, {32'h0003_2000, 32'h0000_0000}, packed N_TGT*ADDR_W base addresses; target i in bits [i*ADDR_W +: ADDR_W]
TGT_MASK, {32'hFFFF_F000, 32'hFFFF_C000}, packed N_TGT*ADDR_W match masks; target i hit when (addr & mask_i) == base_i
TIMEOUT, 15, max wait cycles per target access before error (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  bridge can accept request
req_we  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
req_unsigned  in  1  zero-extend loads (lbu/lhu)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  aligned, extended load data; 0 for stores and errors
rsp_err  out  2  0=ok, 1=misaligned, 2=unmapped, 3=timeout
tgt_sel  out  N_TGT  one-hot target select, held for the duration of the access
tgt_we  out  1  write strobe qualifier
tgt_be  out  4  byte enables
tgt_addr  out  ADDR_W  word-aligned address (bits [1:0]=0)
tgt_wdata  out  32  lane-replicated store data
tgt_rdata  in  N_TGT*32  per-target read words
tgt_ready  in  N_TGT  per-target completion

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; tgt_sel=0; tgt_we=0; tgt_be=0; tgt_addr=0; tgt_wdata=0; timeout counter=0. Assertion mid-access aborts it and produces no response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and decode it.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3) -> RESP with err=1.
  - Else no window hit -> RESP with err=2.
  - Else -> ACCESS.
  - Errored requests never assert tgt_sel.
- Decode: the lowest index wins on overlapping windows.
- ACCESS:
  - req_ready=0; tgt_sel one-hot registered.
  - tgt_addr = {addr[ADDR_W-1:2],2'b00}; tgt_we = req_we.
  - tgt_be (writes and reads alike) = byte: 1<<addr[1:0]; half: addr[1]?1100:0011; word: 1111.
  - tgt_wdata: byte replicated x4; half replicated x2; word as is.
  - The cycle tgt_ready[sel]=1: capture tgt_rdata slice for sel and go to RESP with err=0. A tgt_ready from an unselected target is ignored.
  - The counter increments each ACCESS cycle without ready. At count==TIMEOUT, go to RESP with err=3; the ready is honoured if it arrives in that same cycle.
  - Counter clears on entering ACCESS.
- RESP:
  - rsp_valid=1 for exactly one cycle; tgt_sel/tgt_we/tgt_be return to 0; req_ready=0.
  - Next state is IDLE.
  - A request presented during RESP is not accepted; the core holds it.
- Load alignment:
  - lb/lbu select byte addr[1:0]; lh/lhu select half addr[1].
  - Sign-extend unless req_unsigned=1.
  - lw passes through.
  - Stores return rdata=0.
- Latency:
  - Accept edge N; tgt_sel high from N+1.
  - Ready at N+1 -> rsp_valid at N+2.
  - Errors detected at decode -> rsp_valid at N+1.
  - Throughput: one access per 3 cycles minimum.

Test Plan:
- Load byte signed, addr 0x0000_0002, target0 returns 0x1180_7F22 with ready on the first ACCESS cycle -> tgt_be=0100; rsp_rdata=0xFFFF_FF80; err=0; rsp_valid two cycles after accept.
- Store half 0xBEEF at 0x0000_0106 -> tgt_be=1100, tgt_wdata=0xBEEF_BEEF, tgt_addr=0x104, tgt_we=1; rsp_rdata=0.
- lhu at 0x0003_2003 -> err=1 on the cycle after accept; tgt_sel never asserted. lw at 0x0001_0000 -> err=2.
- Target1 (GPIO) withholds ready for 3 cycles, then returns 0x0000_000A to lw 0x0003_2004 -> rsp_rdata=0xA; rsp_valid exactly once. Target never ready -> err=3 after 15 wait cycles; tgt_sel drops.
- Back-to-back requests held valid -> req_ready low during ACCESS/RESP; each response matches its own request; no request is lost or duplicated.
- rst_n pulsed low mid-ACCESS -> all outputs return to reset values asynchronously; no rsp_valid; the next request after release completes normally.
